adc_sar_seq: RTL and testbench

Multi-channel, oversampling SAR conversion sequencer that drives the mixed-signal SAR ADC model's `ms_*` interface. Scans a channel mask, runs sample, then N bit-trials per conversion. Accumulates 2^osr_log2 conversions per channel and delivers one averaged N-bit result per channel over a valid/ready port. Sits between the register bank/DMA (digital side) and the analog SAR core plus its external input mux.

---
 rtl/adc_sar_pkg.sv | 40 ++++
 rtl/adc_sar_seq_if.sv | 25 ++
 rtl/adc_sar_reg.sv | 53 +++++
 rtl/adc_sar_seq.sv | 201 ++++++++++++++++++++
 tb/tb_adc_sar_seq.sv | 259 +++++++++++++++++++++++++
 5 files changed

// File: rtl/adc_sar_pkg.sv
// Shared types and helpers for the oversampling SAR conversion sequencer.
package adc_sar_pkg;

  localparam int N_DEF        = 12;
  localparam int CH_DEF       = 4;
  localparam int T_SAMPLE_DEF = 4;
  localparam int OSR_MAX_DEF  = 4;

  typedef enum logic [2:0] {
    S_IDLE,
    S_SAMPLE,
    S_TRIAL_HI,
    S_TRIAL_LO,
    S_ACCUM
  } sar_state_t;

  function automatic logic [2:0] clamp_osr(input logic [2:0] req, input int lim);
    if (int'(req) > lim) return 3'(lim);
    return req;
  endfunction

  // Next set mask bit strictly after cur, wrapping; cur = n_ch-1 yields the lowest set bit.
  function automatic int next_channel(input logic [31:0] mask, input int cur, input int n_ch);
    int  j;
    int  nxt;
    bit  found;
    nxt   = cur;
    found = 1'b0;
    for (int i = 1; i <= n_ch; i++) begin
      j = cur + i;
      if (j >= n_ch) j = j - n_ch;
      if (!found && mask[j]) begin
        nxt   = j;
        found = 1'b1;
      end
    end
    return nxt;
  endfunction

endpackage

// File: rtl/adc_sar_seq_if.sv
// Analog-core and result-port signals of the SAR sequencer, bundled for the top port.
interface adc_sar_seq_if #(
  parameter int N  = 12,
  parameter int CW = 2
);
  logic          ms_sample;
  logic          ms_clk;
  logic [N-1:0]  ms_dac;
  logic          ms_cmp;
  logic [CW-1:0] ms_chsel;
  logic          res_valid;
  logic          res_ready;
  logic [N-1:0]  res_data;
  logic [CW-1:0] res_ch;

  modport master (
    output ms_sample, ms_clk, ms_dac, ms_chsel, res_valid, res_data, res_ch,
    input  ms_cmp, res_ready
  );

  modport slave (
    input  ms_sample, ms_clk, ms_dac, ms_chsel, res_valid, res_data, res_ch,
    output ms_cmp, res_ready
  );
endinterface

// File: rtl/adc_sar_reg.sv
// Successive-approximation register: trial code plus bit pointer, resolved one bit per decide.
module adc_sar_reg #(
  parameter int N = 12
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         clr,
  input  logic         load,
  input  logic         trial,
  input  logic         decide,
  input  logic         cmp,
  output logic [N-1:0] code,
  output logic         done
);

  localparam int IW = (N > 1) ? $clog2(N) : 1;

  logic [N-1:0]  code_q, code_nxt;
  logic [IW-1:0] idx_q, idx_nxt;

  always_comb begin
    code_nxt = code_q;
    idx_nxt  = idx_q;
    if (clr) begin
      code_nxt = '0;
      idx_nxt  = '0;
    end else if (load) begin
      code_nxt        = '0;
      code_nxt[N-1]   = 1'b1;
      idx_nxt         = IW'(N - 1);
    end else begin
      if (decide && !cmp) code_nxt[idx_q] = 1'b0;
      if (trial && idx_q != '0) begin
        idx_nxt           = idx_q - IW'(1);
        code_nxt[idx_nxt] = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      code_q <= '0;
      idx_q  <= '0;
    end else begin
      code_q <= code_nxt;
      idx_q  <= idx_nxt;
    end
  end

  assign code = code_q;
  assign done = (idx_q == '0);

endmodule

// File: rtl/adc_sar_seq.sv
// Multi-channel oversampling SAR sequencer: scans ch_mask, averages 2^osr conversions per channel.
//   state      | meaning
//   S_IDLE     | waiting for start with a non-empty mask
//   S_SAMPLE   | track phase, ms_sample high for T_SAMPLE cycles
//   S_TRIAL_HI | comparator strobe high, trial code on ms_dac
//   S_TRIAL_LO | strobe low (comparator fires), bit resolved at cycle end
//   S_ACCUM    | add code to accumulator, emit average after the last conversion
module adc_sar_seq
  import adc_sar_pkg::*;
#(
  parameter int N        = N_DEF,
  parameter int CH       = CH_DEF,
  parameter int T_SAMPLE = T_SAMPLE_DEF,
  parameter int OSR_MAX  = OSR_MAX_DEF
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          start,
  input  logic          abort,
  input  logic          cont,
  input  logic [CH-1:0] ch_mask,
  input  logic [2:0]    osr_log2,
  output logic          busy,
  output logic          ovr,
  adc_sar_seq_if.master bus
);

  localparam int CW      = (CH > 1) ? $clog2(CH) : 1;
  localparam int AW      = N + OSR_MAX;
  localparam int KW      = (OSR_MAX > 0) ? OSR_MAX : 1;
  localparam int TW      = (T_SAMPLE > 1) ? $clog2(T_SAMPLE) : 1;
  localparam int OSR_CAP = (OSR_MAX > 7) ? 7 : OSR_MAX;

  sar_state_t    state_q, state_nxt;
  logic [TW-1:0] smp_cnt_q;
  logic [KW-1:0] conv_left_q;
  logic [AW-1:0] acc_q;
  logic          cont_q;
  logic [CH-1:0] mask_q;
  logic [2:0]    osr_q;
  logic [CW-1:0] ch_q;

  logic          res_valid_q, ovr_q;
  logic [N-1:0]  res_data_q;
  logic [CW-1:0] res_ch_q;

  logic          sar_clr, sar_load, sar_trial, sar_decide, sar_done;
  logic [N-1:0]  sar_code;

  logic [2:0]    osr_in;
  logic [KW-1:0] load_start, load_next;
  logic [CW-1:0] first_ch, nxt_ch;
  logic          scan_wrap, last_conv, res_load;
  logic [AW-1:0] acc_sum;
  logic [N-1:0]  avg;

  adc_sar_reg #(.N(N)) u_sar (
    .clk    (clk),
    .rst_n  (rst_n),
    .clr    (sar_clr),
    .load   (sar_load),
    .trial  (sar_trial),
    .decide (sar_decide),
    .cmp    (bus.ms_cmp),
    .code   (sar_code),
    .done   (sar_done)
  );

  assign osr_in     = clamp_osr(osr_log2, OSR_CAP);
  assign load_start = KW'((32'd1 << osr_in) - 32'd1);
  assign load_next  = KW'((32'd1 << osr_q) - 32'd1);
  assign first_ch   = CW'(next_channel(32'(ch_mask), CH - 1, CH));
  assign nxt_ch     = CW'(next_channel(32'(mask_q), int'(ch_q), CH));
  // A non-increasing next index means the scan has passed its last masked channel.
  assign scan_wrap  = (nxt_ch <= ch_q);
  assign last_conv  = (conv_left_q == '0);
  assign acc_sum    = acc_q + AW'(sar_code);
  assign avg        = N'(acc_sum >> osr_q);
  assign res_load   = (state_q == S_ACCUM) && last_conv && !abort;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= S_IDLE;
    else        state_q <= state_nxt;
  end

  always_comb begin
    state_nxt  = state_q;
    sar_clr    = 1'b0;
    sar_load   = 1'b0;
    sar_trial  = 1'b0;
    sar_decide = 1'b0;
    if (abort) begin
      state_nxt = S_IDLE;
      sar_clr   = 1'b1;
    end else begin
      case (state_q)
        S_IDLE: begin
          sar_clr = 1'b1;
          if (start && ch_mask != '0) state_nxt = S_SAMPLE;
        end
        S_SAMPLE: begin
          if (smp_cnt_q == '0) begin
            sar_load  = 1'b1;
            state_nxt = S_TRIAL_HI;
          end
        end
        S_TRIAL_HI: state_nxt = S_TRIAL_LO;
        S_TRIAL_LO: begin
          sar_decide = 1'b1;
          if (sar_done) begin
            state_nxt = S_ACCUM;
          end else begin
            sar_trial = 1'b1;
            state_nxt = S_TRIAL_HI;
          end
        end
        S_ACCUM: begin
          sar_clr = 1'b1;
          if (!last_conv || cont_q || !scan_wrap) state_nxt = S_SAMPLE;
          else                                    state_nxt = S_IDLE;
        end
        default: state_nxt = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      smp_cnt_q   <= '0;
      conv_left_q <= '0;
      acc_q       <= '0;
      cont_q      <= 1'b0;
      mask_q      <= '0;
      osr_q       <= '0;
      ch_q        <= '0;
    end else begin
      if (state_q != S_SAMPLE && state_nxt == S_SAMPLE)
        smp_cnt_q <= TW'(T_SAMPLE - 1);
      else if (state_q == S_SAMPLE && smp_cnt_q != '0)
        smp_cnt_q <= smp_cnt_q - TW'(1);

      if (abort) begin
        acc_q       <= '0;
        conv_left_q <= '0;
      end else begin
        case (state_q)
          S_IDLE: begin
            if (start && ch_mask != '0) begin
              cont_q      <= cont;
              mask_q      <= ch_mask;
              osr_q       <= osr_in;
              ch_q        <= first_ch;
              conv_left_q <= load_start;
              acc_q       <= '0;
            end
          end
          S_ACCUM: begin
            if (!last_conv) begin
              acc_q       <= acc_sum;
              conv_left_q <= conv_left_q - KW'(1);
            end else begin
              acc_q       <= '0;
              conv_left_q <= load_next;
              if (!scan_wrap || cont_q) ch_q <= nxt_ch;
            end
          end
          default: ;
        endcase
      end
    end
  end

  // Single-entry result holder; the sequencer never waits, so an unread entry is overwritten.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      res_valid_q <= 1'b0;
      res_data_q  <= '0;
      res_ch_q    <= '0;
      ovr_q       <= 1'b0;
    end else if (res_load) begin
      res_valid_q <= 1'b1;
      res_data_q  <= avg;
      res_ch_q    <= ch_q;
      ovr_q       <= res_valid_q && !bus.res_ready;
    end else begin
      ovr_q <= 1'b0;
      if (res_valid_q && bus.res_ready) res_valid_q <= 1'b0;
    end
  end

  assign busy          = (state_q != S_IDLE);
  assign ovr           = ovr_q;
  assign bus.ms_sample = (state_q == S_SAMPLE);
  assign bus.ms_clk    = (state_q == S_TRIAL_HI);
  assign bus.ms_dac    = sar_code;
  assign bus.ms_chsel  = ch_q;
  assign bus.res_valid = res_valid_q;
  assign bus.res_data  = res_data_q;
  assign bus.res_ch    = res_ch_q;

endmodule

// File: tb/tb_adc_sar_seq.sv
// Directed bench for adc_sar_seq with an ideal comparator model (VREF = 1.0, VSSA = 0).
module tb_adc_sar_seq;
  import adc_sar_pkg::*;

  localparam int N  = 12;
  localparam int CH = 4;
  localparam int CW = 2;

  logic          clk      = 1'b0;
  logic          rst_n    = 1'b0;
  logic          start    = 1'b0;
  logic          abort    = 1'b0;
  logic          cont     = 1'b0;
  logic [CH-1:0] ch_mask  = '0;
  logic [2:0]    osr_log2 = '0;
  logic          busy, ovr;

  adc_sar_seq_if #(.N(N), .CW(CW)) bus ();

  adc_sar_seq #(.N(N), .CH(CH), .T_SAMPLE(4), .OSR_MAX(4)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .start    (start),
    .abort    (abort),
    .cont     (cont),
    .ch_mask  (ch_mask),
    .osr_log2 (osr_log2),
    .busy     (busy),
    .ovr      (ovr),
    .bus      (bus)
  );

  always #5 clk = ~clk;

  real  vin [CH];
  real  vin_seq [8];
  int   seq_len  = 0;
  int   seq_base = 0;
  int   conv_no  = 0;
  logic cmp_q    = 1'b0;

  real  tv [3] = '{0.5, 1.2, -0.1};
  int   te [3] = '{2047, 4095, 0};

  assign bus.ms_cmp = cmp_q;

  always @(posedge bus.ms_sample) conv_no++;

  // Comparator latches on the falling strobe edge: 1 when vin > code*VREF/2^N.
  always @(negedge bus.ms_clk) begin
    real v;
    int  k;
    k = conv_no - seq_base - 1;
    v = (k >= 0 && k < seq_len) ? vin_seq[k] : vin[bus.ms_chsel];
    cmp_q = ((real'(bus.ms_dac) / 4096.0) < v);
  end

  int n_checks = 0;
  int n_fail   = 0;
  int n;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_valid(input int limit, output int cnt);
    cnt = 0;
    while (bus.res_valid !== 1'b1 && cnt < limit) begin
      tick();
      cnt++;
    end
    check("valid_seen", {31'd0, bus.res_valid}, 32'd1);
  endtask

  task automatic start_scan(input logic [CH-1:0] m, input logic c, input logic [2:0] o);
    ch_mask  = m;
    cont     = c;
    osr_log2 = o;
    start    = 1'b1;
    tick();
    start    = 1'b0;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog observed=running expected=finished");
    $fatal(1, "watchdog");
  end

  initial begin
    vin = '{0.3, 0.25, 0.5, 0.75};
    bus.res_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("rst_busy",   {31'd0, busy}, 0);
    check("rst_valid",  {31'd0, bus.res_valid}, 0);
    check("rst_sample", {31'd0, bus.ms_sample}, 0);
    check("rst_dac",    32'(bus.ms_dac), 0);
    check("rst_ovr",    {31'd0, ovr}, 0);
    rst_n = 1'b1;
    tick();
    check("idle_busy", {31'd0, busy}, 0);

    // single channel, osr 0, vin 0.3 -> 1228 at cycle 30
    vin[0] = 0.3;
    start_scan(4'b0001, 1'b0, 3'd0);
    check("c1_busy",   {31'd0, busy}, 1);
    check("c1_sample", {31'd0, bus.ms_sample}, 1);
    check("c1_dac",    32'(bus.ms_dac), 0);
    repeat (4) tick();
    check("c5_clk",    {31'd0, bus.ms_clk}, 1);
    check("c5_dac",    32'(bus.ms_dac), 32'h800);
    check("c5_sample", {31'd0, bus.ms_sample}, 0);
    tick();
    check("c6_clk", {31'd0, bus.ms_clk}, 0);
    tick();
    check("c7_dac", 32'(bus.ms_dac), 32'h400);
    wait_valid(100, n);
    check("lat_osr0",  32'(7 + n), 30);
    check("t1_data",   32'(bus.res_data), 1228);
    check("t1_ch",     32'(bus.res_ch), 0);
    check("t1_busy",   {31'd0, busy}, 0);
    check("t1_ovr",    {31'd0, ovr}, 0);
    tick();
    check("hs_drop", {31'd0, bus.res_valid}, 0);

    for (int i = 0; i < 3; i++) begin
      vin[0] = tv[i];
      start_scan(4'b0001, 1'b0, 3'd0);
      wait_valid(100, n);
      check("sweep_lat",  32'(1 + n), 30);
      check("sweep_data", 32'(bus.res_data), 32'(te[i]));
      tick();
    end

    // mask 1010: (1023, ch1) then (3071, ch3), then idle
    start_scan(4'b1010, 1'b0, 3'd0);
    check("mc_chsel1", 32'(bus.ms_chsel), 1);
    wait_valid(100, n);
    check("mc_lat1",  32'(1 + n), 30);
    check("mc_data1", 32'(bus.res_data), 1023);
    check("mc_ch1",   32'(bus.res_ch), 1);
    check("mc_chsel3", 32'(bus.ms_chsel), 3);
    tick();
    wait_valid(100, n);
    check("mc_lat2",  32'(1 + n), 29);
    check("mc_data2", 32'(bus.res_data), 3071);
    check("mc_ch2",   32'(bus.res_ch), 3);
    check("mc_busy",  {31'd0, busy}, 0);
    tick();

    // osr 2 with stepping input: (1228+1228+1269+1269)>>2 = 1248 at cycle 117
    seq_base   = conv_no;
    vin_seq[0] = 0.3;
    vin_seq[1] = 0.3;
    vin_seq[2] = 0.31;
    vin_seq[3] = 0.31;
    seq_len    = 4;
    start_scan(4'b0001, 1'b0, 3'd2);
    wait_valid(300, n);
    check("osr_lat",  32'(1 + n), 117);
    check("osr_data", 32'(bus.res_data), 1248);
    check("osr_busy", {31'd0, busy}, 0);
    seq_len = 0;
    repeat (40) tick();
    check("osr_single", {31'd0, bus.res_valid}, 0);

    // osr 7 clamps to 4: 16 conversions, result at cycle 465
    vin[0] = 0.5;
    start_scan(4'b0001, 1'b0, 3'd7);
    wait_valid(700, n);
    check("clamp_lat",  32'(1 + n), 465);
    check("clamp_data", 32'(bus.res_data), 2047);
    tick();

    // continuous scan without reads: second result overwrites, ovr pulses once
    bus.res_ready = 1'b0;
    seq_base   = conv_no;
    vin_seq[0] = 0.3;
    vin_seq[1] = 0.5;
    seq_len    = 2;
    start_scan(4'b0001, 1'b1, 3'd0);
    wait_valid(100, n);
    check("cont_lat",   32'(1 + n), 30);
    check("cont_data1", 32'(bus.res_data), 1228);
    check("cont_ovr30", {31'd0, ovr}, 0);
    repeat (28) tick();
    check("cont_ovr58",  {31'd0, ovr}, 0);
    check("cont_hold58", 32'(bus.res_data), 1228);
    tick();
    check("cont_ovr59",  {31'd0, ovr}, 1);
    check("cont_data2",  32'(bus.res_data), 2047);
    check("cont_valid59", {31'd0, bus.res_valid}, 1);
    tick();
    check("cont_ovr60",  {31'd0, ovr}, 0);
    check("cont_busy60", {31'd0, busy}, 1);
    abort = 1'b1;
    tick();
    abort = 1'b0;
    check("abort_busy",  {31'd0, busy}, 0);
    check("abort_valid", {31'd0, bus.res_valid}, 1);
    check("abort_data",  32'(bus.res_data), 2047);
    seq_len = 0;

    // async reset during TRIAL_LO, with an unread result still held
    vin[2] = 0.5;
    start_scan(4'b0100, 1'b0, 3'd0);
    check("rl_chsel", 32'(bus.ms_chsel), 2);
    repeat (5) tick();
    check("rl_clk",  {31'd0, bus.ms_clk}, 0);
    check("rl_dac",  32'(bus.ms_dac), 32'h800);
    check("rl_busy", {31'd0, busy}, 1);
    #2;
    rst_n = 1'b0;
    #1;
    check("ar_busy",   {31'd0, busy}, 0);
    check("ar_sample", {31'd0, bus.ms_sample}, 0);
    check("ar_clk",    {31'd0, bus.ms_clk}, 0);
    check("ar_dac",    32'(bus.ms_dac), 0);
    check("ar_chsel",  32'(bus.ms_chsel), 0);
    check("ar_valid",  {31'd0, bus.res_valid}, 0);
    check("ar_data",   32'(bus.res_data), 0);
    check("ar_ch",     32'(bus.res_ch), 0);
    check("ar_ovr",    {31'd0, ovr}, 0);
    rst_n = 1'b1;
    bus.res_ready = 1'b1;
    tick();
    check("post_rst_busy", {31'd0, busy}, 0);

    // start with an empty mask is ignored
    start_scan(4'b0000, 1'b0, 3'd0);
    check("m0_busy", {31'd0, busy}, 0);
    tick();
    check("m0_busy2", {31'd0, busy}, 0);

    // abort wins over a simultaneous start
    ch_mask = 4'b0001;
    start   = 1'b1;
    abort   = 1'b1;
    tick();
    start   = 1'b0;
    abort   = 1'b0;
    check("sa_busy",   {31'd0, busy}, 0);
    check("sa_sample", {31'd0, bus.ms_sample}, 0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
